// File: rtl/coherence_bus_ctrl_pkg.sv
// Shared types and constants for the dual-core coherence bus controller.
package bus_ctrl_pkg;

    localparam int BLK_WORDS = 2;
    localparam int WORD_OFF  = 4;

    typedef enum logic [3:0] {
        IDLE,
        WB0,
        WB1,
        IFETCH,
        SNOOP,
        C2C0,
        C2C1,
        LD0,
        LD1
    } bus_state_t;

    // With two cores the snooper is always the core that is not the requester.
    function automatic logic other_core(input logic id);
        return ~id;
    endfunction

endpackage

// File: rtl/coherence_bus_ctrl_if.sv
// Cache-side and RAM-side signal bundle of the coherence bus controller.
interface coherence_bus_ctrl_if #(
    parameter int NCPU   = 2,
    parameter int WORD_W = 32
);

    logic [NCPU-1:0]             iREN;
    logic [NCPU-1:0][WORD_W-1:0] iaddr;
    logic [NCPU-1:0][WORD_W-1:0] iload;
    logic [NCPU-1:0]             iwait;

    logic [NCPU-1:0]             dREN;
    logic [NCPU-1:0]             dWEN;
    logic [NCPU-1:0][WORD_W-1:0] daddr;
    logic [NCPU-1:0][WORD_W-1:0] dstore;
    logic [NCPU-1:0][WORD_W-1:0] dload;
    logic [NCPU-1:0]             dwait;

    logic [NCPU-1:0]             cctrans;
    logic [NCPU-1:0]             ccwrite;
    logic [NCPU-1:0]             ccwait;
    logic [NCPU-1:0]             ccinv;
    logic [NCPU-1:0][WORD_W-1:0] ccsnoopaddr;

    logic                        ramREN;
    logic                        ramWEN;
    logic [WORD_W-1:0]           ramaddr;
    logic [WORD_W-1:0]           ramstore;
    logic [WORD_W-1:0]           ramload;
    logic                        ram_wait;

    // master: the controller; slave: the caches and the RAM it serves.
    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ccwrite,
               ramload, ram_wait,
        output iload, iwait, dload, dwait, ccwait, ccinv, ccsnoopaddr,
               ramREN, ramWEN, ramaddr, ramstore
    );

    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ccwrite,
               ramload, ram_wait,
        input  iload, iwait, dload, dwait, ccwait, ccinv, ccsnoopaddr,
               ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/coherence_bus_ctrl_rr_arbiter.sv
// Two-input round-robin arbiter: combinational grant, registered tie-break pointer.
module rr_arbiter
    import bus_ctrl_pkg::*;
(
    input  logic       CLK,
    input  logic       nRST,
    input  logic [1:0] req,
    input  logic       take,
    output logic       valid,
    output logic       id
);

    logic ptr;

    always_comb begin
        valid = |req;
        id    = (req == 2'b11) ? ptr : req[1];
    end

    // The pointer only moves when it actually resolved a tie, so a lone
    // requester does not rob the other core of its next turn.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            ptr <= 1'b0;
        else if (take && req == 2'b11)
            ptr <= other_core(id);
    end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// Memory-side controller: arbitrates two icaches and two MSI dcaches onto one RAM and runs snoops.
module coherence_bus_ctrl
    import bus_ctrl_pkg::*;
#(
    parameter int NCPU   = 2,
    parameter int WORD_W = 32
)(
    input logic                  CLK,
    input logic                  nRST,
    coherence_bus_ctrl_if.master bus
);

    bus_state_t state, next_state;
    logic       req, next_req;
    logic       snp;

    logic wb_valid, wb_id, wb_take;
    logic cc_valid, cc_id, cc_take;
    logic if_valid, if_id, if_take;

    logic [NCPU-1:0]             iwait, dwait, ccwait, ccinv;
    logic [NCPU-1:0][WORD_W-1:0] iload, dload, ccsnoopaddr;
    logic                        ramREN, ramWEN;
    logic [WORD_W-1:0]           ramaddr, ramstore;

    assign snp = other_core(req);

    rr_arbiter u_wb_arb (
        .CLK(CLK), .nRST(nRST), .req(bus.dWEN & ~bus.cctrans),
        .take(wb_take), .valid(wb_valid), .id(wb_id)
    );

    rr_arbiter u_cc_arb (
        .CLK(CLK), .nRST(nRST), .req(bus.cctrans),
        .take(cc_take), .valid(cc_valid), .id(cc_id)
    );

    rr_arbiter u_if_arb (
        .CLK(CLK), .nRST(nRST), .req(bus.iREN),
        .take(if_take), .valid(if_valid), .id(if_id)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            req   <= 1'b0;
        end else begin
            state <= next_state;
            req   <= next_req;
        end
    end

    always_comb begin
        next_state  = state;
        next_req    = req;
        wb_take     = 1'b0;
        cc_take     = 1'b0;
        if_take     = 1'b0;
        iwait       = '1;
        dwait       = '1;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        iload       = '0;
        dload       = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;

        case (state)
            IDLE: begin
                if (wb_valid) begin
                    wb_take    = 1'b1;
                    next_req   = wb_id;
                    next_state = WB0;
                end else if (cc_valid) begin
                    cc_take    = 1'b1;
                    next_req   = cc_id;
                    next_state = SNOOP;
                end else if (if_valid) begin
                    if_take    = 1'b1;
                    next_req   = if_id;
                    next_state = IFETCH;
                end
            end

            WB0, WB1: begin
                ramWEN   = 1'b1;
                ramaddr  = bus.daddr[req];
                ramstore = bus.dstore[req];
                if (!bus.ram_wait) begin
                    dwait[req] = 1'b0;
                    next_state = (state == WB0) ? WB1 : IDLE;
                end
            end

            IFETCH: begin
                ramREN     = 1'b1;
                ramaddr    = bus.iaddr[req];
                iload[req] = bus.ramload;
                if (!bus.ram_wait) begin
                    iwait[req] = 1'b0;
                    next_state = IDLE;
                end
            end

            SNOOP: begin
                ccwait[snp]      = 1'b1;
                ccinv[snp]       = bus.ccwrite[req];
                ccsnoopaddr[snp] = bus.daddr[req];
                if (bus.cctrans[snp]) begin
                    if (bus.ccwrite[snp])
                        next_state = C2C0;
                    else if (bus.dREN[req])
                        next_state = LD0;
                    else begin
                        dwait[req] = 1'b0;
                        next_state = IDLE;
                    end
                end
            end

            // Dirty block flows snooper -> requester and is written back to RAM in the same beat.
            C2C0, C2C1: begin
                ccwait[snp]      = 1'b1;
                ccinv[snp]       = bus.ccwrite[req];
                ccsnoopaddr[snp] = bus.daddr[req];
                ramWEN           = 1'b1;
                ramaddr          = bus.daddr[snp];
                ramstore         = bus.dstore[snp];
                dload[req]       = bus.dstore[snp];
                if (!bus.ram_wait) begin
                    dwait[snp] = 1'b0;
                    dwait[req] = 1'b0;
                    next_state = (state == C2C0) ? C2C1 : IDLE;
                end
            end

            LD0, LD1: begin
                ramREN     = 1'b1;
                ramaddr    = bus.daddr[req];
                dload[req] = bus.ramload;
                if (!bus.ram_wait) begin
                    dwait[req] = 1'b0;
                    next_state = (state == LD0) ? LD1 : IDLE;
                end
            end

            default: next_state = IDLE;
        endcase
    end

    assign bus.iwait       = iwait;
    assign bus.iload       = iload;
    assign bus.dwait       = dwait;
    assign bus.dload       = dload;
    assign bus.ccwait      = ccwait;
    assign bus.ccinv       = ccinv;
    assign bus.ccsnoopaddr = ccsnoopaddr;
    assign bus.ramREN      = ramREN;
    assign bus.ramWEN      = ramWEN;
    assign bus.ramaddr     = ramaddr;
    assign bus.ramstore    = ramstore;

endmodule
